imem_loader: RTL and testbench

Writer side of the instruction memory read by the fetch stage. It receives a byte stream from a host link over a valid/ready handshake and assembles REGI_SIZE-bit instruction words. It writes them sequentially into instruction memory from address 0 and holds the core in reset until the image is complete. It sits between the host interface and the imem write port.

---
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream instruction memory writer.
// Assembles 16-bit words and holds the core until the image is loaded.
module imem_loader #(
   parameter int REGI_SIZE  = 16,
   parameter int MEMO_LINES = 64,
   parameter int ADDR_BITS  = 6
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [7:0]           byte_i,
   input  logic                 byte_valid_i,
   output logic                 byte_ready_o,
   output logic                 we_o,
   output logic [ADDR_BITS-1:0] waddr_o,
   output logic [REGI_SIZE-1:0] wdata_o,
   output logic                 core_hold_o,
   output logic                 done_o,
   output logic                 error_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA_LO,
      S_DATA_HI,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [15:0]          r_len;
   logic [ADDR_BITS:0]   r_cnt;
   logic [ADDR_BITS:0]   w_cnt_inc;
   logic [7:0]           r_lo;
   logic [ADDR_BITS-1:0] r_waddr;
   logic [REGI_SIZE-1:0] r_wdata;
   logic [15:0]          w_len_full;
   logic                 w_xfer;
   logic                 w_start;
   logic                 w_last;

   assign w_xfer     = byte_valid_i & byte_ready_o;
   assign w_len_full = {byte_i, r_len[7:0]};
   assign w_cnt_inc  = r_cnt + 1'b1;
   assign w_last     = ({{(15 - ADDR_BITS){1'b0}}, w_cnt_inc} == r_len);
   assign w_start    = start_i & ((r_state == S_IDLE) |
                                  (r_state == S_DONE) |
                                  (r_state == S_ERROR));
   assign waddr_o    = r_waddr;
   assign wdata_o    = r_wdata;

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state and state-decoded outputs
   always_comb begin
      w_next       = r_state;
      byte_ready_o = 1'b0;
      we_o         = 1'b0;
      done_o       = 1'b0;
      error_o      = 1'b0;
      core_hold_o  = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (start_i) w_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            byte_ready_o = 1'b1;
            if (w_xfer) w_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            byte_ready_o = 1'b1;
            if (w_xfer) begin
               if (w_len_full == 16'd0)
                  w_next = S_DONE;
               else if (w_len_full > 16'(MEMO_LINES))
                  w_next = S_ERROR;
               else
                  w_next = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            byte_ready_o = 1'b1;
            if (w_xfer) w_next = S_DATA_HI;
         end
         S_DATA_HI: begin
            byte_ready_o = 1'b1;
            if (w_xfer) w_next = S_WRITE;
         end
         S_WRITE: begin
            we_o   = 1'b1;
            w_next = w_last ? S_DONE : S_DATA_LO;
         end
         S_DONE: begin
            done_o      = 1'b1;
            core_hold_o = 1'b0;
            if (start_i) w_next = S_LEN_LO;
         end
         S_ERROR: begin
            error_o = 1'b1;
            if (start_i) w_next = S_LEN_LO;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Length, byte latch, word counter and write port registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_len   <= '0;
         r_cnt   <= '0;
         r_lo    <= '0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         if (w_start) r_cnt <= '0;
         if (w_xfer) begin
            case (r_state)
               S_LEN_LO:  r_len[7:0]  <= byte_i;
               S_LEN_HI:  r_len[15:8] <= byte_i;
               S_DATA_LO: r_lo        <= byte_i;
               S_DATA_HI: begin
                  r_wdata <= {byte_i, r_lo};
                  r_waddr <= r_cnt[ADDR_BITS-1:0];
               end
               default: ;
            endcase
         end
         if (r_state == S_WRITE) r_cnt <= w_cnt_inc;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vectors for the imem byte-stream loader.
// Writes are logged on the falling edge and compared to hand values.
module tb_imem_loader;

   logic        clk;
   logic        rst_i;
   logic        start_i;
   logic [7:0]  byte_i;
   logic        byte_valid_i;
   logic        byte_ready_o;
   logic        we_o;
   logic [5:0]  waddr_o;
   logic [15:0] wdata_o;
   logic        core_hold_o;
   logic        done_o;
   logic        error_o;

   int          nvec = 0;
   int          nerr = 0;
   int          nw   = 0;
   int          base;
   logic [5:0]  la [0:255];
   logic [15:0] ld [0:255];

   imem_loader dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .byte_ready_o (byte_ready_o),
      .we_o         (we_o),
      .waddr_o      (waddr_o),
      .wdata_o      (wdata_o),
      .core_hold_o  (core_hold_o),
      .done_o       (done_o),
      .error_o      (error_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log every write strobe away from the rising edge
   always @(negedge clk) begin
      if (we_o && nw < 256) begin
         la[nw] = waddr_o;
         ld[nw] = wdata_o;
         nw = nw + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      byte_i       = b;
      byte_valid_i = 1'b1;
      while (!byte_ready_o && t < 50) begin
         cyc();
         t++;
      end
      if (t >= 50) chk("ready_timeout", 32'(t), 32'd0);
      cyc();
      byte_valid_i = 1'b0;
   endtask

   task automatic send_gap(input logic [7:0] b);
      byte_valid_i = 1'b0;
      byte_i       = ~b;
      cyc();
      send_byte(b);
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      cyc();
      start_i = 1'b0;
   endtask

   task automatic chk_outs(input string tag, input logic rdy,
                           input logic we, input logic hold,
                           input logic dn, input logic er);
      chk({tag, "_ready"}, 32'(byte_ready_o), 32'(rdy));
      chk({tag, "_we"},    32'(we_o),         32'(we));
      chk({tag, "_hold"},  32'(core_hold_o),  32'(hold));
      chk({tag, "_done"},  32'(done_o),       32'(dn));
      chk({tag, "_error"}, 32'(error_o),      32'(er));
   endtask

   initial begin
      rst_i        = 1'b0;
      start_i      = 1'b0;
      byte_i       = 8'h00;
      byte_valid_i = 1'b0;
      #1;
      chk_outs("rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("rst_waddr", 32'(waddr_o), 32'h0);
      chk("rst_wdata", 32'(wdata_o), 32'h0);
      cyc();
      cyc();
      rst_i = 1'b1;
      cyc();
      chk_outs("idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Basic 3-word load
      base = nw;
      pulse_start();
      chk("basic_lenlo_ready", 32'(byte_ready_o), 32'd1);
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h34);
      send_byte(8'h12);
      chk("basic_w0_we", 32'(we_o), 32'd1);
      chk("basic_w0_addr", 32'(waddr_o), 32'd0);
      chk("basic_w0_data", 32'(wdata_o), 32'h1234);
      send_byte(8'h78);
      send_byte(8'h56);
      send_byte(8'hBC);
      send_byte(8'h9A);
      chk("basic_w2_we", 32'(we_o), 32'd1);
      chk("basic_w2_hold", 32'(core_hold_o), 32'd1);
      cyc();
      chk_outs("basic_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("basic_nw", 32'(nw - base), 32'd3);
      chk("basic_a0", 32'(la[base]), 32'd0);
      chk("basic_d0", 32'(ld[base]), 32'h1234);
      chk("basic_a1", 32'(la[base+1]), 32'd1);
      chk("basic_d1", 32'(ld[base+1]), 32'h5678);
      chk("basic_a2", 32'(la[base+2]), 32'd2);
      chk("basic_d2", 32'(ld[base+2]), 32'h9ABC);
      cyc();
      chk("done_hold_waddr", 32'(waddr_o), 32'd2);
      chk("done_hold_wdata", 32'(wdata_o), 32'h9ABC);

      // Reload from DONE with backpressure, new image over address 0
      base = nw;
      pulse_start();
      chk_outs("reload", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      send_gap(8'h03);
      send_gap(8'h00);
      send_gap(8'h21);
      send_gap(8'h43);
      send_gap(8'h65);
      send_gap(8'h87);
      send_gap(8'hA9);
      send_gap(8'hCB);
      cyc();
      cyc();
      chk_outs("bp_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("bp_nw", 32'(nw - base), 32'd3);
      chk("bp_a0", 32'(la[base]), 32'd0);
      chk("bp_d0", 32'(ld[base]), 32'h4321);
      chk("bp_a1", 32'(la[base+1]), 32'd1);
      chk("bp_d1", 32'(ld[base+1]), 32'h8765);
      chk("bp_a2", 32'(la[base+2]), 32'd2);
      chk("bp_d2", 32'(ld[base+2]), 32'hCBA9);

      // Zero-length image
      base = nw;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h00);
      chk_outs("n0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
      chk("n0_nw", 32'(nw - base), 32'd0);

      // Oversize image (65 words)
      base = nw;
      pulse_start();
      send_byte(8'h41);
      send_byte(8'h00);
      chk_outs("n65", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc();
      chk("n65_nw", 32'(nw - base), 32'd0);

      // Length with high byte set (256) must also be rejected
      pulse_start();
      chk("err_restart_error", 32'(error_o), 32'd0);
      send_byte(8'h00);
      send_byte(8'h01);
      chk("n256_error", 32'(error_o), 32'd1);

      // Full 64-word image from ERROR
      base = nw;
      pulse_start();
      send_byte(8'h40);
      send_byte(8'h00);
      for (int i = 0; i < 64; i++) begin
         send_byte(8'(i));
         send_byte(8'(i) ^ 8'hA5);
      end
      cyc();
      chk_outs("n64", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("n64_nw", 32'(nw - base), 32'd64);
      for (int i = 0; i < 64; i++) begin
         chk("n64_addr", 32'(la[base+i]), 32'(i));
         chk("n64_data", 32'(ld[base+i]),
             32'({8'(i) ^ 8'hA5, 8'(i)}));
      end

      // Reset after the low byte of word 1
      base = nw;
      pulse_start();
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      #3;
      rst_i = 1'b0;
      #1;
      chk_outs("abort", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("abort_waddr", 32'(waddr_o), 32'd0);
      byte_valid_i = 1'b1;
      byte_i       = 8'h44;
      cyc();
      cyc();
      byte_valid_i = 1'b0;
      rst_i = 1'b1;
      cyc();
      chk("abort_nw", 32'(nw - base), 32'd1);
      chk("abort_d0", 32'(ld[base]), 32'h2211);

      // 1-word image, start pulsed while in DATA_HI
      base = nw;
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h55);
      pulse_start();
      chk("ign_ready", 32'(byte_ready_o), 32'd1);
      chk("ign_done", 32'(done_o), 32'd0);
      send_byte(8'h66);
      chk("ign_we", 32'(we_o), 32'd1);
      chk("ign_addr", 32'(waddr_o), 32'd0);
      chk("ign_data", 32'(wdata_o), 32'h6655);
      cyc();
      chk_outs("ign_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
      chk("ign_nw", 32'(nw - base), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
